// File: rtl/me_mem_arbiter_if.sv
// Requester/memory bundle shared by the ME read-port arbiter and its environment.
// master drives requests and memory data; slave (the arbiter) drives grants, stalls and returns.
interface me_mem_arbiter_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              pause0;
    logic              pause1;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid0;
    logic              rd_valid1;

    modport master (
        output req0, addr0, req1, addr1, mem_rdata,
        input  pause0, pause1, mem_re, mem_addr, rd_data, rd_valid0, rd_valid1
    );

    modport slave (
        input  req0, addr0, req1, addr1, mem_rdata,
        output pause0, pause1, mem_re, mem_addr, rd_data, rd_valid0, rd_valid1
    );
endinterface

// File: rtl/me_mem_arbiter.sv
// Round-robin burst arbiter for one frame-memory read port; grant is combinational, data returns RD_LAT cycles after mem_re.
// Losing requester is held through pauseK; switching owners costs no dead cycle.
module me_mem_arbiter #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16,
    parameter int BURST  = 32,
    parameter int RD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    me_mem_arbiter_if.slave bus
);
    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              last_owner, last_owner_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_own;
    logic              owner;
    logic              req_own;
    logic              req_oth;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] rdata;

    assign owner = (state == G1);

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        cnt_nxt        = cnt;
        req_own        = owner ? bus.req1 : bus.req0;
        req_oth        = owner ? bus.req0 : bus.req1;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.req0 && bus.req1)
                    state_nxt = last_owner ? G0 : G1;
                else if (bus.req0)
                    state_nxt = G0;
                else if (bus.req1)
                    state_nxt = G1;
            end
            G0, G1: begin
                if (req_oth && (cnt == CNT_MAX || !req_own)) begin
                    state_nxt      = owner ? G0 : G1;
                    last_owner_nxt = owner;
                    cnt_nxt        = '0;
                end else if (!req_own && !req_oth) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = owner;
                    cnt_nxt        = '0;
                end else begin
                    // sole requester keeps the port; counter just wraps
                    cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            cnt        <= '0;
            pipe_vld   <= '0;
            pipe_own   <= '0;
        end else begin
            state       <= state_nxt;
            last_owner  <= last_owner_nxt;
            cnt         <= cnt_nxt;
            pipe_vld[0] <= bus.mem_re;
            pipe_own[0] <= owner;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_own[i] <= pipe_own[i-1];
            end
        end
    end

    always_comb begin
        addr_sel = '0;
        if (state == G0)
            addr_sel = bus.addr0;
        else if (state == G1)
            addr_sel = bus.addr1;
    end

    assign rdata         = bus.mem_rdata;
    assign bus.rd_data   = rdata;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_re    = ((state == G0) && bus.req0) || ((state == G1) && bus.req1);
    assign bus.pause0    = bus.req0 && (state != G0);
    assign bus.pause1    = bus.req1 && (state != G1);
    assign bus.rd_valid0 = pipe_vld[RD_LAT-1] && !pipe_own[RD_LAT-1];
    assign bus.rd_valid1 = pipe_vld[RD_LAT-1] &&  pipe_own[RD_LAT-1];
endmodule

// File: tb/tb_me_mem_arbiter.sv
// Bench: two arbiters (read latency 2 and 3) on shared requester stimulus, checked against a reference model and return scoreboards.
module tb_me_mem_arbiter;
    localparam int AW    = 23;
    localparam int DW    = 16;
    localparam int BURST = 32;
    localparam int LAT_A = 2;
    localparam int LAT_B = 3;

    typedef struct {
        bit          own;
        logic [15:0] dat;
        int          due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;

    me_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    me_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    assign ifa.req0 = req0;  assign ifa.req1 = req1;
    assign ifa.addr0 = addr0; assign ifa.addr1 = addr1;
    assign ifb.req0 = req0;  assign ifb.req1 = req1;
    assign ifb.addr0 = addr0; assign ifb.addr1 = addr1;

    me_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST(BURST), .RD_LAT(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    me_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST(BURST), .RD_LAT(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [AW-1:0] a);
        return a[15:0] ^ {a[22:16], 9'h0A5};
    endfunction

    // synchronous memories with fixed read latency
    logic [15:0] mpa [LAT_A];
    logic [15:0] mpb [LAT_B];
    always @(posedge clk) begin
        mpa[0] <= memf(ifa.mem_addr);
        mpa[1] <= mpa[0];
        mpb[0] <= memf(ifb.mem_addr);
        mpb[1] <= mpb[0];
        mpb[2] <= mpb[1];
    end
    assign ifa.mem_rdata = mpa[LAT_A-1];
    assign ifb.mem_rdata = mpb[LAT_B-1];

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   m_st = 0;            // 0 idle, 1 requester 0 owns, 2 requester 1 owns
    bit   m_last = 1'b1;
    int   m_cnt = 0;
    exp_t sba[$];
    exp_t sbb[$];
    int   iss [2];
    int   ret [2][2];
    int   g0_seen, g1_seen, gap_seen, re_seen;
    logic s_pause0, s_pause1, s_re;
    logic [AW-1:0] seq0, seq1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h, expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic check_ret(input int inst, input logic v0, input logic v1, input logic [15:0] d);
        exp_t  e;
        bit    have;
        string t;
        have = 1'b0;
        t = (inst == 0) ? "_a" : "_b";
        if (inst == 0 && sba.size() > 0) begin e = sba[0]; have = 1'b1; end
        if (inst == 1 && sbb.size() > 0) begin e = sbb[0]; have = 1'b1; end
        if (have && e.due == cyc) begin
            check_eq({"ret_vld", t}, 32'({v1, v0}), e.own ? 32'd2 : 32'd1);
            check_eq({"ret_dat", t}, 32'(d), 32'(e.dat));
            if (inst == 0) void'(sba.pop_front()); else void'(sbb.pop_front());
            if (v0) ret[inst][0]++;
            if (v1) ret[inst][1]++;
        end else begin
            check_eq({"no_ret", t}, 32'({v1, v0}), 32'd0);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_last = 1'b1; m_cnt = 0;
        sba.delete(); sbb.delete();
    endtask

    task automatic cycle();
        bit            m_re, mine, other;
        logic [AW-1:0] m_addr;
        @(negedge clk);
        m_re   = (m_st == 1 && req0) || (m_st == 2 && req1);
        m_addr = (m_st == 1) ? addr0 : (m_st == 2) ? addr1 : '0;
        check_eq("mem_re_a",   32'(ifa.mem_re),   32'(m_re));
        check_eq("mem_re_b",   32'(ifb.mem_re),   32'(m_re));
        check_eq("mem_addr_a", 32'(ifa.mem_addr), 32'(m_addr));
        check_eq("pause0_a",   32'(ifa.pause0),   32'(req0 && m_st != 1));
        check_eq("pause1_a",   32'(ifa.pause1),   32'(req1 && m_st != 2));
        check_eq("pause0_b",   32'(ifb.pause0),   32'(req0 && m_st != 1));
        check_eq("pause1_b",   32'(ifb.pause1),   32'(req1 && m_st != 2));
        check_ret(0, ifa.rd_valid0, ifa.rd_valid1, ifa.rd_data);
        check_ret(1, ifb.rd_valid0, ifb.rd_valid1, ifb.rd_data);
        s_pause0 = ifa.pause0; s_pause1 = ifa.pause1; s_re = ifa.mem_re;
        if (ifa.mem_re && ifa.pause1) g0_seen++;
        if (ifa.mem_re && ifa.pause0) g1_seen++;
        if (!ifa.mem_re) gap_seen++;
        if (ifa.mem_re) re_seen++;
        if (m_re && rst) begin
            sba.push_back('{own: (m_st == 2), dat: memf(m_addr), due: cyc + LAT_A});
            sbb.push_back('{own: (m_st == 2), dat: memf(m_addr), due: cyc + LAT_B});
            iss[(m_st == 2) ? 1 : 0]++;
        end
        if (!rst) begin
            model_reset();
        end else if (m_st == 0) begin
            m_cnt = 0;
            if (req0 && req1) m_st = m_last ? 1 : 2;
            else if (req0)    m_st = 1;
            else if (req1)    m_st = 2;
        end else begin
            mine  = (m_st == 1) ? req0 : req1;
            other = (m_st == 1) ? req1 : req0;
            if (other && (m_cnt == BURST - 1 || !mine)) begin
                m_last = (m_st == 2); m_st = 3 - m_st; m_cnt = 0;
            end else if (!other && !mine) begin
                m_last = (m_st == 2); m_st = 0; m_cnt = 0;
            end else begin
                m_cnt = (m_cnt + 1) % BURST;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // granted requesters present sequential addresses; paused ones wander randomly
    task automatic drive(input bit r0, input bit r1);
        req0 = r0; req1 = r1;
        if (m_st == 1 && r0) begin addr0 = seq0; seq0 = seq0 + AW'(2); end
        else addr0 = AW'($urandom);
        if (m_st == 2 && r1) begin addr1 = seq1; seq1 = seq1 + AW'(2); end
        else addr1 = AW'($urandom);
    endtask

    task automatic run(input bit r0, input bit r1, input int n);
        for (int i = 0; i < n; i++) begin
            drive(r0, r1);
            cycle();
        end
    endtask

    task automatic clear_counts();
        iss = '{0, 0};
        ret = '{'{0, 0}, '{0, 0}};
        g0_seen = 0; g1_seen = 0; gap_seen = 0; re_seen = 0;
    endtask

    task automatic totals(input string tag);
        run(1'b0, 1'b0, 6);
        check_eq({tag, "_r0_a"}, 32'(ret[0][0]), 32'(iss[0]));
        check_eq({tag, "_r1_a"}, 32'(ret[0][1]), 32'(iss[1]));
        check_eq({tag, "_r0_b"}, 32'(ret[1][0]), 32'(iss[0]));
        check_eq({tag, "_r1_b"}, 32'(ret[1][1]), 32'(iss[1]));
        clear_counts();
    endtask

    initial begin
        seq0 = '0; seq1 = AW'(24'h40000);
        clear_counts();
        model_reset();
        #1;
        // reset held with both requesting
        run(1'b1, 1'b1, 3);
        check_eq("rst_pause0", 32'(s_pause0), 32'd1);
        check_eq("rst_pause1", 32'(s_pause1), 32'd1);
        check_eq("rst_mem_re", 32'(s_re), 32'd0);
        rst = 1'b1;
        run(1'b1, 1'b1, 1);
        run(1'b1, 1'b1, 1);
        check_eq("first_grant_g0", 32'(s_pause0), 32'd0);
        // contention: 32 + 32 with no gap (first G0 cycle already consumed)
        g0_seen = 0; g1_seen = 0; gap_seen = 0;
        run(1'b1, 1'b1, 63);
        check_eq("cont_g0_len", 32'(g0_seen), 32'd31);
        check_eq("cont_g1_len", 32'(g1_seen), 32'd32);
        check_eq("cont_gaps", 32'(gap_seen), 32'd0);
        run(1'b1, 1'b1, 20);
        totals("cont");

        // single requester, 100 reads with stepping addresses
        seq0 = '0;
        run(1'b1, 1'b0, 101);
        check_eq("single_reads", 32'(re_seen), 32'd100);
        run(1'b0, 1'b0, 6);
        check_eq("single_rv0_a", 32'(ret[0][0]), 32'd100);
        check_eq("single_rv0_b", 32'(ret[1][0]), 32'd100);
        check_eq("single_rv1_a", 32'(ret[0][1]), 32'd0);
        clear_counts();

        // early release at cnt=10 hands over with a fresh burst count
        run(1'b1, 1'b0, 1);
        run(1'b1, 1'b1, 10);
        run(1'b0, 1'b1, 1);
        g1_seen = 0;
        run(1'b1, 1'b1, 32);
        check_eq("early_g1_len", 32'(g1_seen), 32'd32);
        run(1'b1, 1'b1, 1);
        check_eq("early_back_g0", 32'(s_pause0), 32'd0);
        totals("early");

        // release to idle by requester 0, then contention favours requester 1
        run(1'b1, 1'b0, 5);
        run(1'b0, 1'b0, 2);
        run(1'b1, 1'b1, 1);
        run(1'b1, 1'b1, 1);
        check_eq("rr_g1_first", 32'(s_pause1), 32'd0);
        check_eq("rr_p0_held", 32'(s_pause0), 32'd1);
        totals("rr");

        // random traffic exercising routing across both latencies
        for (int i = 0; i < 400; i++)
            run($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 1);
        totals("rand");

        // reset with reads in flight, then requester 0 must win again
        run(1'b1, 1'b1, 6);
        rst = 1'b0;
        model_reset();
        run(1'b1, 1'b1, 2);
        check_eq("mid_rst_re", 32'(s_re), 32'd0);
        check_eq("mid_rst_p1", 32'(s_pause1), 32'd1);
        rst = 1'b1;
        clear_counts();
        run(1'b1, 1'b1, 1);
        run(1'b1, 1'b1, 1);
        check_eq("mid_rst_g0", 32'(s_pause0), 32'd0);
        run(1'b1, 1'b1, 40);
        totals("mid_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
